semaforo_cruzamento: RTL and testbench



---
 rtl/semaforo_cruzamento.sv | 144 ++++++++++++++
 tb/tb_semaforo_cruzamento.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/semaforo_cruzamento.sv
// semaforo_cruzamento: two-way (A/B) traffic-light controller with all-red clearance,
// one-shot pedestrian green shortening and a night flashing-yellow mode.
// Optional pedestrian lamps pedestre_a/pedestre_b are enabled by defining SEMAFORO_PEDESTRE_EN.
module semaforo_cruzamento #(
    parameter int T_VERDE   = 20,
    parameter int T_AMARELO = 10,
    parameter int T_LIMPEZA = 2,
    parameter int T_PISCA   = 4,
    parameter int CW        = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       botao,
    input  logic       modo_noturno,
    output logic       verde_a,
    output logic       amarelo_a,
    output logic       vermelho_a,
    output logic       verde_b,
    output logic       amarelo_b,
    output logic       vermelho_b,
`ifdef SEMAFORO_PEDESTRE_EN
    output logic       pedestre_a,
    output logic       pedestre_b,
`endif
    output logic [2:0] fase
);

    typedef enum logic [2:0] {
        VERDE_A = 3'd0,
        AMAR_A  = 3'd1,
        LIMP_A  = 3'd2,
        VERDE_B = 3'd3,
        AMAR_B  = 3'd4,
        LIMP_B  = 3'd5,
        PISCA   = 3'd6
    } estado_t;

    localparam logic [CW-1:0] V_FIM = CW'(T_VERDE - 1);
    localparam logic [CW-1:0] A_FIM = CW'(T_AMARELO - 1);
    localparam logic [CW-1:0] L_FIM = CW'(T_LIMPEZA - 1);
    localparam logic [CW-1:0] P_FIM = CW'(T_PISCA - 1);

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic [CW-1:0] limite;
    logic [CW-1:0] salto;
    logic          encurtou;
    logic          pisca;
    logic          fim;
    logic          em_verde;
    logic          em_amarelo;
    logic          em_limpeza;

    // Phase class, terminal count of the current phase and the shortened green target
    always_comb begin
        em_verde   = (estado == VERDE_A) || (estado == VERDE_B);
        em_amarelo = (estado == AMAR_A) || (estado == AMAR_B);
        em_limpeza = (estado == LIMP_A) || (estado == LIMP_B);
        limite     = em_verde ? V_FIM : em_amarelo ? A_FIM : em_limpeza ? L_FIM : P_FIM;
        fim        = (cnt == limite);
        salto      = cnt + 1'b1 + ((V_FIM - cnt) >> 1);
    end

    // Phase sequencing, pedestrian shortening and night-mode flashing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= LIMP_B;
            cnt      <= '0;
            encurtou <= 1'b0;
            pisca    <= 1'b0;
        end else begin
            case (estado)
                VERDE_A, VERDE_B: begin
                    if (fim) begin
                        estado <= (estado == VERDE_A) ? AMAR_A : AMAR_B;
                        cnt    <= '0;
                    end else if (botao && !encurtou) begin
                        cnt      <= salto;
                        encurtou <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                AMAR_A, AMAR_B: begin
                    if (fim) begin
                        estado <= (estado == AMAR_A) ? LIMP_A : LIMP_B;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LIMP_A, LIMP_B: begin
                    if (fim) begin
                        cnt      <= '0;
                        encurtou <= 1'b0;
                        if (modo_noturno) begin
                            estado <= PISCA;
                            pisca  <= 1'b1;
                        end else begin
                            estado <= (estado == LIMP_A) ? VERDE_B : VERDE_A;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PISCA: begin
                    if (!modo_noturno) begin
                        estado <= LIMP_B;
                        cnt    <= '0;
                    end else if (fim) begin
                        cnt   <= '0;
                        pisca <= ~pisca;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    estado <= LIMP_B;
                    cnt    <= '0;
                end
            endcase
        end
    end

    // Lamp decode straight from the registered state; anything unknown shows red both ways
    always_comb begin
        verde_a    = (estado == VERDE_A);
        amarelo_a  = (estado == AMAR_A) || ((estado == PISCA) && pisca);
        vermelho_a = !((estado == VERDE_A) || (estado == AMAR_A) || (estado == PISCA));
        verde_b    = (estado == VERDE_B);
        amarelo_b  = (estado == AMAR_B) || ((estado == PISCA) && pisca);
        vermelho_b = !((estado == VERDE_B) || (estado == AMAR_B) || (estado == PISCA));
        fase       = estado;
    end

`ifdef SEMAFORO_PEDESTRE_EN
    // Pedestrians cross way A while B has green, and vice versa
    always_comb begin
        pedestre_a = (estado == VERDE_B);
        pedestre_b = (estado == VERDE_A);
    end
`endif

endmodule

// File: tb/tb_semaforo_cruzamento.sv
// tb_semaforo_cruzamento: directed-vector bench for semaforo_cruzamento (default parameters).
module tb_semaforo_cruzamento;

    localparam int T_PISCA = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       botao;
    logic       modo_noturno;
    logic       verde_a, amarelo_a, vermelho_a;
    logic       verde_b, amarelo_b, vermelho_b;
    logic [2:0] fase;
    logic [7:0] lamp;
    int         n_cmp = 0;
    int         n_err = 0;
    int         pk = 0;
    logic [2:0] fs[$];
    int         ns[$];
    logic       bs[$];
    logic       ms[$];

`ifdef SEMAFORO_PEDESTRE_EN
    logic pedestre_a, pedestre_b;
    assign lamp = {pedestre_a, pedestre_b, verde_a, amarelo_a, vermelho_a, verde_b, amarelo_b, vermelho_b};
`else
    assign lamp = {2'b00, verde_a, amarelo_a, vermelho_a, verde_b, amarelo_b, vermelho_b};
`endif

    semaforo_cruzamento dut (
        .clock(clock),
        .reset_n(reset_n),
        .botao(botao),
        .modo_noturno(modo_noturno),
        .verde_a(verde_a),
        .amarelo_a(amarelo_a),
        .vermelho_a(vermelho_a),
        .verde_b(verde_b),
        .amarelo_b(amarelo_b),
        .vermelho_b(vermelho_b),
`ifdef SEMAFORO_PEDESTRE_EN
        .pedestre_a(pedestre_a),
        .pedestre_b(pedestre_b),
`endif
        .fase(fase)
    );

    always #5 clock = ~clock;

    // Expected {ped_a, ped_b, verde_a, amarelo_a, vermelho_a, verde_b, amarelo_b, vermelho_b}
    function automatic logic [7:0] exp_lamp(input logic [2:0] f, input logic p);
        logic [7:0] e;
        case (f)
            3'd0:    e = 8'b00_100_001;
            3'd1:    e = 8'b00_010_001;
            3'd3:    e = 8'b00_001_100;
            3'd4:    e = 8'b00_001_010;
            3'd6:    e = {2'b00, 1'b0, p, 1'b0, 1'b0, p, 1'b0};
            default: e = 8'b00_001_001;
        endcase
`ifdef SEMAFORO_PEDESTRE_EN
        e[7] = (f == 3'd3);
        e[6] = (f == 3'd0);
`endif
        return e;
    endfunction

    task automatic add(input logic [2:0] f, input int n, input logic b, input logic m);
        fs.push_back(f);
        ns.push_back(n);
        bs.push_back(b);
        ms.push_back(m);
    endtask

    task automatic limpa();
        fs.delete();
        ns.delete();
        bs.delete();
        ms.delete();
        pk = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        botao = 1'b0;
        modo_noturno = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (fase !== 3'd5 || lamp !== exp_lamp(3'd5, 1'b0)) begin
            n_err++;
            $display("FAIL reset: fase=%0d lamps=%b, expected fase=5 lamps=%b", fase, lamp, exp_lamp(3'd5, 1'b0));
        end
        reset_n = 1'b1;
    endtask

    task automatic test_ciclo_normal();
        limpa();
        add(3'd5, 2, 0, 0); add(3'd0, 20, 0, 0); add(3'd1, 10, 0, 0); add(3'd2, 2, 0, 0);
        add(3'd3, 20, 0, 0); add(3'd4, 10, 0, 0); add(3'd5, 2, 0, 0);
        for (int s = 0; s < ns.size(); s++)
            for (int k = 0; k < ns[s]; k++) begin
                botao = bs[s];
                modo_noturno = ms[s];
                n_cmp++;
                if (fase !== fs[s] || lamp !== exp_lamp(fs[s], 1'b0)) begin
                    n_err++;
                    $display("FAIL ciclo_normal seg%0d k%0d: fase=%0d lamps=%b, expected fase=%0d lamps=%b", s, k, fase, lamp, fs[s], exp_lamp(fs[s], 1'b0));
                end
                @(negedge clock);
            end
    endtask

    task automatic test_botao_encurta();
        limpa();
        add(3'd0, 3, 0, 0); add(3'd0, 1, 1, 0); add(3'd0, 8, 0, 0); add(3'd1, 10, 0, 0);
        add(3'd2, 2, 0, 0); add(3'd3, 20, 0, 0); add(3'd4, 10, 0, 0); add(3'd5, 2, 0, 0);
        for (int s = 0; s < ns.size(); s++)
            for (int k = 0; k < ns[s]; k++) begin
                botao = bs[s];
                modo_noturno = ms[s];
                n_cmp++;
                if (fase !== fs[s] || lamp !== exp_lamp(fs[s], 1'b0)) begin
                    n_err++;
                    $display("FAIL botao_encurta seg%0d k%0d: fase=%0d lamps=%b, expected fase=%0d lamps=%b", s, k, fase, lamp, fs[s], exp_lamp(fs[s], 1'b0));
                end
                @(negedge clock);
            end
        botao = 1'b0;
    endtask

    task automatic test_botao_segurado();
        limpa();
        add(3'd0, 20, 0, 0); add(3'd1, 10, 0, 0); add(3'd2, 2, 0, 0); add(3'd3, 11, 1, 0);
        add(3'd4, 10, 0, 0); add(3'd5, 2, 0, 0);
        for (int s = 0; s < ns.size(); s++)
            for (int k = 0; k < ns[s]; k++) begin
                botao = bs[s];
                modo_noturno = ms[s];
                n_cmp++;
                if (fase !== fs[s] || lamp !== exp_lamp(fs[s], 1'b0)) begin
                    n_err++;
                    $display("FAIL botao_segurado seg%0d k%0d: fase=%0d lamps=%b, expected fase=%0d lamps=%b", s, k, fase, lamp, fs[s], exp_lamp(fs[s], 1'b0));
                end
                @(negedge clock);
            end
        botao = 1'b0;
    endtask

    task automatic test_botao_ignorado();
        limpa();
        add(3'd0, 19, 0, 0); add(3'd0, 1, 1, 0); add(3'd1, 10, 1, 0); add(3'd2, 2, 1, 0);
        add(3'd3, 20, 0, 0); add(3'd4, 10, 1, 0); add(3'd5, 2, 1, 0);
        for (int s = 0; s < ns.size(); s++)
            for (int k = 0; k < ns[s]; k++) begin
                botao = bs[s];
                modo_noturno = ms[s];
                n_cmp++;
                if (fase !== fs[s] || lamp !== exp_lamp(fs[s], 1'b0)) begin
                    n_err++;
                    $display("FAIL botao_ignorado seg%0d k%0d: fase=%0d lamps=%b, expected fase=%0d lamps=%b", s, k, fase, lamp, fs[s], exp_lamp(fs[s], 1'b0));
                end
                @(negedge clock);
            end
        botao = 1'b0;
    endtask

    task automatic test_noturno();
        logic ep;
        limpa();
        add(3'd0, 5, 0, 0); add(3'd0, 15, 0, 1); add(3'd1, 10, 0, 1); add(3'd2, 2, 0, 1);
        add(3'd6, 12, 0, 1); add(3'd6, 1, 0, 0); add(3'd5, 2, 0, 0);
        add(3'd0, 20, 0, 0); add(3'd1, 10, 0, 0); add(3'd2, 2, 0, 0);
        add(3'd3, 20, 0, 0); add(3'd4, 5, 0, 0);
        for (int s = 0; s < ns.size(); s++)
            for (int k = 0; k < ns[s]; k++) begin
                botao = bs[s];
                modo_noturno = ms[s];
                ep = (fs[s] == 3'd6) && (((pk / T_PISCA) % 2) == 0);
                pk = (fs[s] == 3'd6) ? pk + 1 : 0;
                n_cmp++;
                if (fase !== fs[s] || lamp !== exp_lamp(fs[s], ep)) begin
                    n_err++;
                    $display("FAIL noturno seg%0d k%0d: fase=%0d lamps=%b, expected fase=%0d lamps=%b", s, k, fase, lamp, fs[s], exp_lamp(fs[s], ep));
                end
                @(negedge clock);
            end
    endtask

    task automatic test_reset_assincrono();
        n_cmp++;
        if (fase !== 3'd4) begin
            n_err++;
            $display("FAIL reset_assincrono pre: fase=%0d, expected fase=4", fase);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (fase !== 3'd5 || lamp !== exp_lamp(3'd5, 1'b0)) begin
            n_err++;
            $display("FAIL reset_assincrono imediato: fase=%0d lamps=%b, expected fase=5 lamps=%b", fase, lamp, exp_lamp(3'd5, 1'b0));
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if (fase !== 3'd5 || lamp !== exp_lamp(3'd5, 1'b0)) begin
            n_err++;
            $display("FAIL reset_assincrono mantido: fase=%0d lamps=%b, expected fase=5 lamps=%b", fase, lamp, exp_lamp(3'd5, 1'b0));
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ciclo_normal();
        test_botao_encurta();
        test_botao_segurado();
        test_botao_ignorado();
        test_noturno();
        test_reset_assincrono();
        test_ciclo_normal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
